// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I subset produced by the loader and consumed by the decoder.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package riscv_pkg;

  // Major opcodes; the main decoder matches against these same constants.
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Descriptor kinds; codes 4..7 are illegal.
  typedef enum logic [2:0] {
    K_LW  = 3'd0,
    K_SW  = 3'd1,
    K_R   = 3'd2,
    K_BEQ = 3'd3
  } kind_e;

  // Loader session states.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCEPT = 2'd1,
    S_WRITE  = 2'd2,
    S_DONE   = 2'd3
  } ld_state_e;

endpackage

// File: rtl/instr_encoder.sv
// Combinational encoder: descriptor fields -> RV32I word plus illegal-kind flag.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller registers the result.
module instr_encoder
  import riscv_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic [3:0]  funct,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [11:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  // Field packing per kind; for BEQ, imm carries branch offset bits [12:1].
  always_comb begin
    word    = 32'h0;
    illegal = 1'b0;
    case (kind)
      K_LW:  word = {imm, rs1, 3'b010, rd, OP_LOAD};
      K_SW:  word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_STORE};
      K_R:   word = {1'b0, funct[3], 5'b0, rs2, rs1, funct[2:0], rd, OP_RTYPE};
      K_BEQ: word = {imm[11], imm[9:4], rs2, rs1, 3'b000, imm[3:0], imm[10], OP_BRANCH};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_loader.sv
// Session loader: encodes accepted descriptors and writes them to consecutive imem words.
// Latency: handshake at edge N -> write strobe in cycle N+1 -> ready again in cycle N+2.
// Backpressure: in_ready is high only in ACCEPT, so at most one descriptor per two cycles.
module instr_loader
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [3:0]        in_funct,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [11:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  localparam int unsigned CAP = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CAP_CNT = CAP[ADDR_W:0];

  ld_state_e         state, state_nx;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   cnt;
  logic              err_q;
  logic [31:0]       word_q;
  logic              ill_q;
  logic              last_q;
  logic [31:0]       enc_word;
  logic              enc_ill;
  logic              full;
  logic              accept;
  logic              wr_ok;

  instr_encoder u_enc (
    .kind    (in_kind),
    .funct   (in_funct),
    .rd      (in_rd),
    .rs1     (in_rs1),
    .rs2     (in_rs2),
    .imm     (in_imm),
    .word    (enc_word),
    .illegal (enc_ill)
  );

  assign full   = (cnt == CAP_CNT);
  assign accept = (state == S_ACCEPT) && in_valid;
  // A WRITE only strobes memory for a legal word with room left.
  assign wr_ok  = (state == S_WRITE) && !ill_q && !full;

  // State register; reset drops straight to IDLE so outputs clear asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic for the session sequence.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start)  state_nx = S_ACCEPT;
      S_ACCEPT: if (accept) state_nx = S_WRITE;
      S_WRITE:  state_nx = last_q ? S_DONE : S_ACCEPT;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Session datapath: pointer, word count, sticky error and the captured descriptor.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr    <= '0;
      cnt    <= '0;
      err_q  <= 1'b0;
      word_q <= 32'h0;
      ill_q  <= 1'b0;
      last_q <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        ptr   <= base_addr;
        cnt   <= '0;
        err_q <= 1'b0;
      end
      if (accept) begin
        word_q <= enc_word;
        ill_q  <= enc_ill;
        last_q <= in_last;
      end
      if (state == S_WRITE) begin
        if (wr_ok) begin
          ptr <= ptr + 1'b1;
          cnt <= cnt + 1'b1;
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

  // Outputs depend on registers only.
  assign in_ready  = (state == S_ACCEPT);
  assign mem_we    = wr_ok;
  assign mem_addr  = ptr;
  assign mem_wdata = word_q;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign err       = err_q;
  assign count     = cnt;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: two instances (ADDR_W=8 and ADDR_W=2) sharing descriptor inputs.
// Latency: n/a.
// Backpressure: n/a.
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start2;
  logic [7:0]  base_addr;
  logic [1:0]  base_addr2;
  logic        in_valid;
  logic [2:0]  in_kind;
  logic [3:0]  in_funct;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [11:0] in_imm;
  logic        in_last;

  logic        in_ready, mem_we, busy, done, err;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [8:0]  count;

  logic        in_ready2, mem_we2, busy2, done2, err2;
  logic [1:0]  mem_addr2;
  logic [31:0] mem_wdata2;
  logic [2:0]  count2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_loader #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind), .in_funct(in_funct),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err), .count(count)
  );

  instr_loader #(.ADDR_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .base_addr(base_addr2),
    .in_valid(in_valid), .in_ready(in_ready2), .in_kind(in_kind), .in_funct(in_funct),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
    .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .busy(busy2), .done(done2), .err(err2), .count(count2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_desc(input logic [2:0] k, input logic [3:0] f, input logic [4:0] rd,
                          input logic [4:0] r1, input logic [4:0] r2, input logic [11:0] im,
                          input logic lst);
    in_kind = k; in_funct = f; in_rd = rd; in_rs1 = r1; in_rs2 = r2; in_imm = im; in_last = lst;
  endtask

  // Present a descriptor, wait (bounded) for ready, handshake, and return in the WRITE cycle.
  task automatic send(input bit sel, input logic [2:0] k, input logic [3:0] f, input logic [4:0] rd,
                      input logic [4:0] r1, input logic [4:0] r2, input logic [11:0] im,
                      input logic lst);
    int n;
    set_desc(k, f, rd, r1, r2, im, lst);
    in_valid = 1'b1;
    n = 0;
    while (!(sel ? in_ready2 : in_ready) && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk("ready_timeout", 32'd0, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; start2 = 1'b0; base_addr = 8'h0; base_addr2 = 2'h0;
    in_valid = 1'b0;
    set_desc(3'd0, 4'd0, 5'd0, 5'd0, 5'd0, 12'd0, 1'b0);
    tick(); tick();
    // Reset state
    chk("rst_ready", in_ready, 0);  chk("rst_we", mem_we, 0);   chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);       chk("rst_err", err, 0);     chk("rst_count", count, 0);
    chk("rst_addr", mem_addr, 0);   chk("rst_wdata", mem_wdata, 0);
    rst = 1'b0;
    tick();
    chk("idle_ready", in_ready, 0);

    // Single LW, last
    base_addr = 8'h00; start = 1'b1; tick(); start = 1'b0;
    chk("start_ready", in_ready, 1); chk("start_busy", busy, 1);
    send(0, 3'd0, 4'd0, 5'd5, 5'd2, 5'd0, 12'd8, 1'b1);
    chk("lw_we", mem_we, 1); chk("lw_addr", mem_addr, 8'h00); chk("lw_data", mem_wdata, 32'h00812283);
    chk("lw_ready_wr", in_ready, 0);
    tick();
    chk("lw_done", done, 1); chk("lw_count", count, 1); chk("lw_we_off", mem_we, 0);
    tick();
    chk("lw_idle_busy", busy, 0); chk("lw_done_off", done, 0);

    // SW, SUB, BEQ at base 0x10
    base_addr = 8'h10; start = 1'b1; tick(); start = 1'b0;
    send(0, 3'd1, 4'd0, 5'd0, 5'd2, 5'd6, 12'd12, 1'b0);
    chk("sw_we", mem_we, 1); chk("sw_addr", mem_addr, 8'h10); chk("sw_data", mem_wdata, 32'h00612623);
    tick();
    send(0, 3'd2, 4'b1000, 5'd1, 5'd2, 5'd3, 12'd0, 1'b0);
    chk("sub_addr", mem_addr, 8'h11); chk("sub_data", mem_wdata, 32'h403100B3);
    tick();
    send(0, 3'd3, 4'd0, 5'd0, 5'd1, 5'd2, 12'hFFC, 1'b1);
    chk("beq_addr", mem_addr, 8'h12); chk("beq_data", mem_wdata, 32'hFE208CE3);
    tick();
    chk("seq_done", done, 1); chk("seq_count", count, 3);
    tick();

    // Wraparound with in_valid held high
    base_addr = 8'hFE; start = 1'b1; tick(); start = 1'b0;
    set_desc(3'd0, 4'd0, 5'd1, 5'd0, 5'd0, 12'd0, 1'b0);
    in_valid = 1'b1;
    chk("wr0_ready", in_ready, 1);
    tick();
    chk("wr0_we", mem_we, 1); chk("wr0_addr", mem_addr, 8'hFE); chk("wr0_data", mem_wdata, 32'h00002083);
    chk("wr0_ready_low", in_ready, 0);
    set_desc(3'd0, 4'd0, 5'd2, 5'd0, 5'd0, 12'd0, 1'b0);
    tick();
    chk("wr1_ready", in_ready, 1); chk("wr1_we_gap", mem_we, 0);
    tick();
    chk("wr1_addr", mem_addr, 8'hFF); chk("wr1_data", mem_wdata, 32'h00002103);
    set_desc(3'd0, 4'd0, 5'd3, 5'd0, 5'd0, 12'd0, 1'b1);
    tick();
    chk("wr2_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("wr2_we", mem_we, 1); chk("wr2_addr", mem_addr, 8'h00); chk("wr2_data", mem_wdata, 32'h00002183);
    tick();
    chk("wrap_done", done, 1); chk("wrap_count", count, 3);
    tick();

    // Illegal kind followed by a legal LW
    base_addr = 8'h20; start = 1'b1; tick(); start = 1'b0;
    send(0, 3'd7, 4'd0, 5'd1, 5'd1, 5'd1, 12'd1, 1'b0);
    chk("ill_we", mem_we, 0);
    tick();
    chk("ill_err", err, 1); chk("ill_count", count, 0);
    send(0, 3'd0, 4'd0, 5'd5, 5'd2, 5'd0, 12'd8, 1'b1);
    chk("ill_lw_we", mem_we, 1); chk("ill_lw_addr", mem_addr, 8'h20);
    tick();
    chk("ill_done_err", err, 1); chk("ill_done_count", count, 1);
    tick();
    chk("ill_idle_err", err, 1);
    start = 1'b1; tick(); start = 1'b0;
    chk("ill_cleared", err, 0);
    send(0, 3'd0, 4'd0, 5'd1, 5'd0, 5'd0, 12'd0, 1'b1);
    tick(); tick();

    // Memory-full suppression on the 2-bit instance
    base_addr2 = 2'd0; start2 = 1'b1; tick(); start2 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(1, 3'd0, 4'd0, 5'(i + 1), 5'd0, 5'd0, 12'd0, (i == 4));
      chk("full_we", mem_we2, (i < 4) ? 32'd1 : 32'd0);
      if (i < 4) chk("full_addr", mem_addr2, i);
      tick();
    end
    chk("full_done", done2, 1); chk("full_err", err2, 1); chk("full_count", count2, 4);
    chk("dut_quiet", busy, 0);
    tick();

    // Reset asserted during WRITE
    base_addr = 8'h40; start = 1'b1; tick(); start = 1'b0;
    send(0, 3'd0, 4'd0, 5'd5, 5'd2, 5'd0, 12'd8, 1'b0);
    chk("mid_we", mem_we, 1);
    #1 rst = 1'b1;
    #1;
    chk("mid_we_drop", mem_we, 0); chk("mid_busy_drop", busy, 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("post_ready", in_ready, 0); chk("post_count", count, 0);
    chk("post_busy", busy, 0); chk("post_we", mem_we, 0);
    tick();
    chk("post_we2", mem_we, 0); chk("post_err", err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
